// File: rtl/vga_pixel_pipe_pkg.sv
// Constants and types shared by the VGA pixel pipeline and its timing generator.
package vga_pixel_pipe_pkg;

  localparam int VIS_W      = 640;
  localparam int VIS_H      = 480;
  localparam int DS_SHIFT   = 2;
  localparam int COLOR_W    = 8;
  localparam int COORD_W    = 10;
  localparam int ADDR_W     = 15;
  localparam int SYNC_W     = 3;
  localparam int SYNC_DEPTH = 3;

  typedef struct packed {
    logic hs;
    logic vs;
    logic vis;
  } sync_bits_t;

  // Idle level of the delayed sync bundle: syncs are active-low, pixel not visible.
  localparam sync_bits_t SYNC_RESET = '{hs: 1'b1, vs: 1'b1, vis: 1'b0};

  function automatic logic [COLOR_W-1:0] expand_bit(input logic b);
    return {COLOR_W{b}};
  endfunction

endpackage

// File: rtl/vga_pixel_pipe_sync_delay.sv
// Parameterised-depth shift register that keeps sync and blank aligned with colour.
module vga_sync_delay #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= RESET_VAL;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipe.sv
// Three-stage VGA pixel pipeline: screen coordinates -> framebuffer address -> colour,
// with sync and blank delayed so they leave together with the colour of the same pixel.
module vga_pixel_pipe
  import vga_pixel_pipe_pkg::*;
#(
  parameter int X_OFFSET = 146,
  parameter int Y_OFFSET = 1,
  parameter int FB_W     = 160,
  parameter int FB_H     = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] in_X,
  input  logic [COORD_W-1:0] in_Y,
  input  logic               in_display,
  input  logic               in_HS,
  input  logic               in_VS,
  output logic [ADDR_W-1:0]  fb_addr,
  input  logic [2:0]         fb_data,
  output logic [COLOR_W-1:0] vga_R,
  output logic [COLOR_W-1:0] vga_G,
  output logic [COLOR_W-1:0] vga_B,
  output logic               vga_HS,
  output logic               vga_VS,
  output logic               vga_BLANK_N,
  output logic [7:0]         frame_count
);

  if (FB_W * FB_H > (1 << ADDR_W)) begin : g_fb_size_check
    $error("vga_pixel_pipe: framebuffer does not fit in the address width");
  end

  logic [COORD_W-1:0] col_next, row_next;
  logic [COORD_W-1:0] col_s0, row_s0;
  logic               vis_next, vis_s0, vis_s1;
  logic [ADDR_W-1:0]  addr_next;
  logic               vs_prev;
  sync_bits_t         sync_in, sync_out;

  // Negative coordinates wrap to large values, so the range test also rejects them.
  assign col_next = in_X - COORD_W'(X_OFFSET);
  assign row_next = in_Y - COORD_W'(Y_OFFSET);
  assign vis_next = in_display && (col_next < COORD_W'(VIS_W)) && (row_next < COORD_W'(VIS_H));

  assign addr_next = ADDR_W'(row_s0 >> DS_SHIFT) * ADDR_W'(FB_W) + ADDR_W'(col_s0 >> DS_SHIFT);

  always_ff @(posedge clk) begin
    if (reset) begin
      col_s0  <= '0;
      row_s0  <= '0;
      vis_s0  <= 1'b0;
      fb_addr <= '0;
      vis_s1  <= 1'b0;
    end else begin
      col_s0  <= col_next;
      row_s0  <= row_next;
      vis_s0  <= vis_next;
      fb_addr <= vis_s0 ? addr_next : '0;
      vis_s1  <= vis_s0;
    end
  end

  // fb_data answers the address registered one cycle earlier, so it lines up with vis_s1.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_R <= '0;
      vga_G <= '0;
      vga_B <= '0;
    end else begin
      vga_R <= vis_s1 ? expand_bit(fb_data[2]) : '0;
      vga_G <= vis_s1 ? expand_bit(fb_data[1]) : '0;
      vga_B <= vis_s1 ? expand_bit(fb_data[0]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev     <= 1'b1;
      frame_count <= '0;
    end else begin
      vs_prev <= in_VS;
      if (vs_prev && !in_VS) frame_count <= frame_count + 8'd1;
    end
  end

  assign sync_in = {in_HS, in_VS, vis_next};

  vga_sync_delay #(
    .DEPTH    (SYNC_DEPTH),
    .WIDTH    (SYNC_W),
    .RESET_VAL(SYNC_RESET)
  ) u_sync_delay (
    .clk  (clk),
    .reset(reset),
    .d    (sync_in),
    .q    (sync_out)
  );

  assign vga_HS      = sync_out.hs;
  assign vga_VS      = sync_out.vs;
  assign vga_BLANK_N = sync_out.vis;

endmodule
